// File: rtl/aisys_pkg.sv
// Shared types for the AI-system datapath: pixel type, pool FSM states and
// a signed max helper used by the pooling stage.
package aisys_pkg;

   localparam int AISYS_DATA_W = 16;
   localparam int AISYS_DIM_W  = 8;

   typedef logic signed [AISYS_DATA_W-1:0] pix_t;

   typedef enum logic [1:0] {
      POOL_IDLE  = 2'd0,
      POOL_RUN   = 2'd1,
      POOL_DRAIN = 2'd2,
      POOL_DONE  = 2'd3
   } pool_state_t;

   function automatic pix_t smax(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Half-row line buffer for 2x2 pooling: one pair-max per even-row column pair.
// Single port; even rows only write and odd rows only read.
module maxpool_linebuf
   import aisys_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pix_t          wdata,
   output pix_t          rdata
);

   pix_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// 2x2 / stride-2 max-pool over a row-major signed pixel stream.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_2x2_stream
   import aisys_pkg::*;
#(
   parameter int DATA_W = AISYS_DATA_W,
   parameter int MAX_W  = 64,
   parameter int DIM_W  = AISYS_DIM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pool_en,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              pool_done,
   output logic              pool_err,
   output logic [1:0]        dbg_state
);

   localparam int LB_DEPTH = MAX_W / 2;
   localparam int LB_AW    = $clog2(LB_DEPTH);
   localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
   localparam logic [DIM_W-1:0] DIM_TWO = DIM_W'(2);
   localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_W);

   pool_state_t      state_q, state_d;
   logic             pool_en_q;
   logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
   logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
   pix_t             hold_q, hold_d;
   pix_t             out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             pool_done_q, pool_done_d;
   logic             pool_err_q, pool_err_d;
   logic             err_q, err_d;

   pix_t             in_pix, lb_rdata, lb_wdata, pool_max, pooled;
   logic             lb_we;
   logic [LB_AW-1:0] lb_addr;
   logic             start, cfg_bad, accept, col_last, row_last, out_is_last;

   // Both handshakes transfer on a rising edge where valid && ready; a raised
   // out_valid keeps out_data/out_last stable until out_ready is seen.
   assign in_ready = (state_q == POOL_RUN) & pool_en & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign start    = pool_en & ~pool_en_q;
   assign cfg_bad  = (cfg_width < DIM_TWO) | (cfg_height < DIM_TWO) | (cfg_width > DIM_MAX);

   assign in_pix      = in_data;
   assign col_last    = (col_q == width_q - DIM_ONE);
   assign row_last    = (row_q == height_q - DIM_ONE);
   assign out_is_last = (row_q == ((height_q & ~DIM_ONE) - DIM_ONE)) &&
                        (col_q == ((width_q & ~DIM_ONE) - DIM_ONE));

   assign lb_addr  = col_q[LB_AW:1];
   assign lb_wdata = smax(hold_q, in_pix);
   assign pool_max = smax(smax(hold_q, in_pix), lb_rdata);

`ifdef MAXPOOL_RELU_EN
   assign pooled = pool_max[DATA_W-1] ? '0 : pool_max;
`else
   assign pooled = pool_max;
`endif

   maxpool_linebuf #(
      .DEPTH (LB_DEPTH),
      .AW    (LB_AW)
   ) u_linebuf (
      .clk   (clk),
      .we    (lb_we),
      .addr  (lb_addr),
      .wdata (lb_wdata),
      .rdata (lb_rdata)
   );

   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      row_d       = row_q;
      col_d       = col_q;
      hold_d      = hold_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      pool_done_d = 1'b0;
      pool_err_d  = 1'b0;
      err_d       = err_q;
      lb_we       = 1'b0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         POOL_IDLE: begin
            if (start) begin
               width_d  = cfg_width;
               height_d = cfg_height;
               row_d    = '0;
               col_d    = '0;
               err_d    = cfg_bad;
               state_d  = cfg_bad ? POOL_DONE : POOL_RUN;
            end
         end
         POOL_RUN: begin
            if (!pool_en) begin
               state_d     = POOL_IDLE;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else if (accept) begin
               // Trailing odd column/row pixels fall into no-output slots.
               case ({row_q[0], col_q[0]})
                  2'b01: lb_we = 1'b1;
                  2'b11: begin
                     out_data_d  = pooled;
                     out_valid_d = 1'b1;
                     out_last_d  = out_is_last;
                  end
                  default: hold_d = in_pix;
               endcase
               if (col_last) begin
                  col_d = '0;
                  row_d = row_q + DIM_ONE;
               end else begin
                  col_d = col_q + DIM_ONE;
               end
               if (col_last && row_last) begin
                  state_d = POOL_DRAIN;
               end
            end
         end
         POOL_DRAIN: begin
            if (!pool_en) begin
               state_d     = POOL_IDLE;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else if (!out_valid_q) begin
               state_d = POOL_DONE;
            end
         end
         default: begin
            pool_done_d = 1'b1;
            pool_err_d  = err_q;
            state_d     = POOL_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= POOL_IDLE;
         // Starts high so an enable already asserted at reset release is not an edge.
         pool_en_q   <= 1'b1;
         width_q     <= '0;
         height_q    <= '0;
         row_q       <= '0;
         col_q       <= '0;
         hold_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pool_done_q <= 1'b0;
         pool_err_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pool_en_q   <= pool_en;
         width_q     <= width_d;
         height_q    <= height_d;
         row_q       <= row_d;
         col_q       <= col_d;
         hold_q      <= hold_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         pool_done_q <= pool_done_d;
         pool_err_q  <= pool_err_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign pool_done = pool_done_q;
   assign pool_err  = pool_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream with an expected-output queue and a
// free-running output monitor.
module tb_maxpool_2x2_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pool_en;
   logic [7:0]  cfg_width, cfg_height;
   logic [15:0] in_data;
   logic        in_valid, in_ready;
   logic [15:0] out_data;
   logic        out_valid, out_ready, out_last;
   logic        pool_done, pool_err;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int accepted_cnt = 0, ready_seen_cnt = 0, done_cnt = 0;
   int done_cyc = 0, hs_cyc = 0, ready_mode = 0;
   logic done_err = 1'b0, prev_done = 1'b0, prev_stall = 1'b0;
   logic [16:0] prev_word = '0;
   logic [16:0] exp_q[$];
   logic [15:0] frame_pix[$];

   maxpool_2x2_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pool_en    (pool_en),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .pool_done  (pool_done),
      .pool_err   (pool_err),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rl(input logic [15:0] v);
`ifdef MAXPOOL_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   // ---------------- downstream ready driver ----------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [16:0] w;
      logic [16:0] e;
      w = {out_last, out_data};
      if (in_valid && in_ready) accepted_cnt++;
      if (in_ready) ready_seen_cnt++;
      if (pool_done) begin
         check("done_one_cycle", {31'b0, prev_done}, 32'd0);
         done_cnt++;
         done_cyc = cyc;
         done_err = pool_err;
      end
      prev_done = pool_done;
      if (out_valid) begin
         if (prev_stall) check("stall_stable", {15'b0, w}, {15'b0, prev_word});
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_unexpected: got %0h expected nothing", w);
            end else begin
               e = exp_q.pop_front();
               check("out_pix", {15'b0, w}, {15'b0, e});
            end
            if (out_last) hs_cyc = cyc + 1;
         end
         prev_stall = !out_ready;
         prev_word  = w;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_pix(input logic [15:0] p);
      int   g   = 0;
      logic acc = 1'b0;
      in_valid = 1'b1;
      in_data  = p;
      while (!acc && g < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         g++;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout: pixel %0h not accepted", p);
      end
   endtask

   task automatic run_frame(input logic [7:0] w, input logic [7:0] h, input int rmode,
                            input bit chk_lat);
      int n  = frame_pix.size();
      int a0 = accepted_cnt;
      int d0 = done_cnt;
      int g  = 0;
      ready_mode = rmode;
      cfg_width  = w;
      cfg_height = h;
      @(posedge clk);
      #1;
      pool_en = 1'b1;
      foreach (frame_pix[i]) send_pix(frame_pix[i]);
      in_valid = 1'b0;
      while (done_cnt == d0 && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("frame_done", done_cnt - d0, 32'd1);
      if (chk_lat) check("done_latency", done_cyc - hs_cyc, 32'd2);
      check("done_err", {31'b0, done_err}, 32'd0);
      check("pix_accepted", accepted_cnt - a0, n);
      check("queue_drained", exp_q.size(), 32'd0);
      pool_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic bad_cfg(input logic [7:0] w, input logic [7:0] h);
      int r0 = ready_seen_cnt;
      int a0 = accepted_cnt;
      int d0 = done_cnt;
      cfg_width  = w;
      cfg_height = h;
      in_valid   = 1'b1;
      in_data    = 16'h1234;
      pool_en    = 1'b1;
      @(posedge clk);
      #1;
      check("bad_cfg_early", {31'b0, pool_done}, 32'd0);
      @(posedge clk);
      #1;
      check("bad_cfg_done", {31'b0, pool_done}, 32'd1);
      check("bad_cfg_err", {31'b0, pool_err}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("bad_cfg_single_done", done_cnt - d0, 32'd1);
      check("bad_cfg_no_ready", ready_seen_cnt - r0, 32'd0);
      check("bad_cfg_no_accept", accepted_cnt - a0, 32'd0);
      check("bad_cfg_idle", {30'b0, dbg_state}, 32'd0);
      in_valid = 1'b0;
      pool_en  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic load_ramp(input int n);
      frame_pix.delete();
      for (int i = 0; i < n; i++) frame_pix.push_back(16'(i));
   endtask

   task automatic push_4x4_ramp();
      exp_q.push_back({1'b0, rl(16'd5)});
      exp_q.push_back({1'b0, rl(16'd7)});
      exp_q.push_back({1'b0, rl(16'd13)});
      exp_q.push_back({1'b1, rl(16'd15)});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      int a0;
      rst_n      = 1'b0;
      pool_en    = 1'b0;
      cfg_width  = '0;
      cfg_height = '0;
      in_data    = '0;
      in_valid   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", {16'b0, out_data}, 32'd0);
      check("rst_out_last", {31'b0, out_last}, 32'd0);
      check("rst_pool_done", {31'b0, pool_done}, 32'd0);
      check("rst_pool_err", {31'b0, pool_err}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_state", {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 4x4 ramp, full throughput then stalling downstream
      load_ramp(16);
      push_4x4_ramp();
      run_frame(8'd4, 8'd4, 0, 1'b1);
      push_4x4_ramp();
      run_frame(8'd4, 8'd4, 1, 1'b1);

      // 5x3 all -3: odd column and odd row are consumed but discarded
      frame_pix.delete();
      for (int i = 0; i < 15; i++) frame_pix.push_back(16'hFFFD);
      exp_q.push_back({1'b0, rl(16'hFFFD)});
      exp_q.push_back({1'b1, rl(16'hFFFD)});
      run_frame(8'd5, 8'd3, 0, 1'b0);

      // signed comparisons
      frame_pix = '{16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF};
      exp_q.push_back({1'b1, rl(16'h7FFF)});
      run_frame(8'd2, 8'd2, 0, 1'b1);
      frame_pix = '{16'h8000, 16'hFFFB, 16'hFF9C, 16'h8000};
      exp_q.push_back({1'b1, rl(16'hFFFB)});
      run_frame(8'd2, 8'd2, 1, 1'b1);

      // 4x2: maxima coming from the line buffer in both windows
      frame_pix = '{16'd9, 16'd1, 16'd2, 16'd8, 16'd3, 16'd4, 16'd7, 16'd6};
      exp_q.push_back({1'b0, rl(16'd9)});
      exp_q.push_back({1'b1, rl(16'd8)});
      run_frame(8'd4, 8'd2, 1, 1'b1);

      // rejected configurations
      bad_cfg(8'd1, 8'd4);
      bad_cfg(8'd80, 8'd4);
      bad_cfg(8'd4, 8'd1);

      // abort after 6 pixels with the output stalled
      ready_mode = 2;
      cfg_width  = 8'd4;
      cfg_height = 8'd4;
      @(posedge clk);
      #1;
      d0 = done_cnt;
      pool_en = 1'b1;
      for (int i = 0; i < 6; i++) send_pix(16'(i));
      in_valid = 1'b0;
      check("abort_pre_valid", {31'b0, out_valid}, 32'd1);
      check("abort_pre_data", {16'b0, out_data}, {16'b0, rl(16'd5)});
      pool_en = 1'b0;
      @(posedge clk);
      #1;
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_state", {30'b0, dbg_state}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 32'd0);

      load_ramp(16);
      push_4x4_ramp();
      run_frame(8'd4, 8'd4, 0, 1'b1);

      // asynchronous reset in the middle of a frame
      ready_mode = 2;
      @(posedge clk);
      #1;
      pool_en = 1'b1;
      for (int i = 0; i < 6; i++) send_pix(16'(i));
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_out_data", {16'b0, out_data}, 32'd0);
      check("mid_rst_out_last", {31'b0, out_last}, 32'd0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a0 = accepted_cnt;
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_no_restart", {30'b0, dbg_state}, 32'd0);
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("post_rst_no_accept", accepted_cnt - a0, 32'd0);
      check("post_rst_no_done", done_cnt - d0, 32'd0);
      in_valid = 1'b0;
      pool_en  = 1'b0;
      @(posedge clk);
      #1;

      load_ramp(16);
      push_4x4_ramp();
      run_frame(8'd4, 8'd4, 1, 1'b1);

      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
